// File: rtl/led_pulse_stretcher.sv
// LED pulse stretcher: each rising edge of event_in becomes one ON_CYCLES-long flash
// followed by an OFF_CYCLES dark gap; edges seen mid-flash are queued and replayed.
module led_pulse_stretcher #(
   parameter int unsigned ON_CYCLES  = 1000,
   parameter int unsigned OFF_CYCLES = 250,
   parameter int unsigned PEND_W     = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              event_in,
   input  logic              clear_drop,
   output logic              led,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              dropped
);

   localparam int unsigned MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

   typedef enum logic [1:0] {StIdle, StOn, StGap} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               prev_q;
   logic               led_d, busy_d, dropped_d;
   logic [PEND_W-1:0]  pending_d;
   logic               rise, final_gap, pend_inc, pend_dec, drop_set;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending;
      drop_set  = 1'b0;

      rise      = event_in & ~prev_q;
      final_gap = (state_q == StGap) && (cnt_q == '0);

      unique case (state_q)
         StIdle: begin
            if (rise) begin
               state_d = StOn;
               cnt_d   = ON_LOAD;
            end
         end
         StOn: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = StGap;
               cnt_d   = OFF_LOAD;
            end
         end
         StGap: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if ((pending != '0) || rise) begin
               state_d = StOn;
               cnt_d   = ON_LOAD;
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      // A rise on the last gap cycle with an empty queue starts the flash directly.
      pend_inc = rise && (state_q != StIdle) && !(final_gap && (pending == '0));
      pend_dec = final_gap && (pending != '0);

      if (pend_inc && pend_dec) begin
         pending_d = pending;
      end else if (pend_dec) begin
         pending_d = pending - PEND_W'(1);
      end else if (pend_inc) begin
         if (pending == PEND_MAX) begin
            drop_set = 1'b1;
         end else begin
            pending_d = pending + PEND_W'(1);
         end
      end

      dropped_d = drop_set | (dropped & ~clear_drop);
      led_d     = (state_d == StOn);
      busy_d    = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         prev_q  <= 1'b0;
         led     <= 1'b0;
         busy    <= 1'b0;
         pending <= '0;
         dropped <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prev_q  <= event_in;
         led     <= led_d;
         busy    <= busy_d;
         pending <= pending_d;
         dropped <= dropped_d;
      end
   end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher with ON_CYCLES=4, OFF_CYCLES=2, PEND_W=3.
module tb_led_pulse_stretcher;

   localparam int unsigned ON_C  = 4;
   localparam int unsigned OFF_C = 2;
   localparam int unsigned PW    = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          event_in;
   logic          clear_drop;
   logic          led;
   logic          busy;
   logic [PW-1:0] pending;
   logic          dropped;

   int checks   = 0;
   int failures = 0;

   led_pulse_stretcher #(
      .ON_CYCLES (ON_C),
      .OFF_CYCLES(OFF_C),
      .PEND_W    (PW)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .event_in  (event_in),
      .clear_drop(clear_drop),
      .led       (led),
      .busy      (busy),
      .pending   (pending),
      .dropped   (dropped)
   );

   always #5 clk = ~clk;

   // Advance one clock edge; inputs change and outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      event_in   = 1'b1;
      clear_drop = 1'b0;
      #2;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({led, busy, pending, dropped} !== '0) begin
            failures++;
            $display("FAIL reset_state cyc=%0d got led=%b busy=%b pend=%0d drop=%b want all 0",
                     i, led, busy, pending, dropped);
         end
      end
      reset = 1'b0;
      step();
      checks++;
      if (led !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_rise got led=%b want 1", led);
      end
      event_in = 1'b0;
      repeat (8) step();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_idle got busy=%b want 0", busy);
      end
   endtask

   task automatic test_single();
      logic [0:7] led_e;
      logic [0:7] busy_e;
      led_e  = 8'b11110000;
      busy_e = 8'b11111100;
      for (int i = 0; i < 8; i++) begin
         event_in = (i == 0);
         step();
         checks++;
         if (led !== led_e[i] || busy !== busy_e[i] || pending !== '0) begin
            failures++;
            $display("FAIL single cyc=%0d got led=%b busy=%b pend=%0d want led=%b busy=%b pend=0",
                     i, led, busy, pending, led_e[i], busy_e[i]);
         end
      end
   endtask

   task automatic test_held();
      int   flashes;
      logic lp;
      flashes = 0;
      lp      = led;
      for (int i = 0; i < 36; i++) begin
         event_in = (i < 30);
         step();
         if (led && !lp) flashes++;
         lp = led;
         checks++;
         if (pending !== '0) begin
            failures++;
            $display("FAIL held_pending cyc=%0d got %0d want 0", i, pending);
         end
      end
      checks++;
      if (flashes != 1) begin
         failures++;
         $display("FAIL held_flash_count got %0d want 1", flashes);
      end
   endtask

   task automatic test_queue();
      logic [0:25] ev;
      logic [0:25] led_e;
      logic [0:25] busy_e;
      int          pend_e [26];
      ev     = 26'b10101001000000000000000000;
      led_e  = 26'b11110011110011110011110000;
      busy_e = 26'b11111111111111111111111100;
      pend_e = '{0, 0, 1, 1, 2, 2, 1, 2, 2, 2, 2, 2, 1,
                 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 26; i++) begin
         event_in = ev[i];
         step();
         checks++;
         if (led !== led_e[i] || busy !== busy_e[i] || int'(pending) != pend_e[i]) begin
            failures++;
            $display("FAIL queue cyc=%0d got led=%b busy=%b pend=%0d want led=%b busy=%b pend=%0d",
                     i, led, busy, pending, led_e[i], busy_e[i], pend_e[i]);
         end
      end
   endtask

   task automatic test_last_gap();
      logic [0:13] ev;
      logic [0:13] led_e;
      logic [0:13] busy_e;
      ev     = 14'b10000010000000;
      led_e  = 14'b11110011110000;
      busy_e = 14'b11111111111100;
      for (int i = 0; i < 14; i++) begin
         event_in = ev[i];
         step();
         checks++;
         if (led !== led_e[i] || busy !== busy_e[i] || pending !== '0) begin
            failures++;
            $display("FAIL last_gap cyc=%0d got led=%b busy=%b pend=%0d want led=%b busy=%b pend=0",
                     i, led, busy, pending, led_e[i], busy_e[i]);
         end
      end
   endtask

   task automatic test_saturate();
      int   flashes;
      logic lp;
      flashes = 0;
      lp      = led;
      for (int i = 0; i < 72; i++) begin
         event_in = (i <= 22) && (i % 2 == 0);
         step();
         if (led && !lp) flashes++;
         lp = led;
         if (i == 21) begin
            checks++;
            if (pending !== 3'd7 || dropped !== 1'b0) begin
               failures++;
               $display("FAIL sat_full got pend=%0d drop=%b want pend=7 drop=0", pending, dropped);
            end
         end
         if (i == 22) begin
            checks++;
            if (pending !== 3'd7 || dropped !== 1'b1) begin
               failures++;
               $display("FAIL sat_drop got pend=%0d drop=%b want pend=7 drop=1", pending, dropped);
            end
         end
         if (i == 24) begin
            checks++;
            if (pending !== 3'd6) begin
               failures++;
               $display("FAIL sat_first_replay got pend=%0d want 6", pending);
            end
         end
         if (i == 60) begin
            checks++;
            if (pending !== 3'd0) begin
               failures++;
               $display("FAIL sat_last_replay got pend=%0d want 0", pending);
            end
         end
         if (i == 66) begin
            checks++;
            if (busy !== 1'b0) begin
               failures++;
               $display("FAIL sat_idle got busy=%b want 0", busy);
            end
         end
      end
      checks++;
      if (flashes != 11) begin
         failures++;
         $display("FAIL sat_flash_count got %0d want 11", flashes);
      end
      checks++;
      if (dropped !== 1'b1) begin
         failures++;
         $display("FAIL sat_sticky got drop=%b want 1", dropped);
      end
      clear_drop = 1'b1;
      step();
      clear_drop = 1'b0;
      checks++;
      if (dropped !== 1'b0) begin
         failures++;
         $display("FAIL sat_clear got drop=%b want 0", dropped);
      end
   endtask

   task automatic test_async_reset();
      event_in = 1'b1; step();
      event_in = 1'b0; step();
      event_in = 1'b1; step();
      event_in = 1'b0; step();
      checks++;
      if (led !== 1'b1 || pending !== 3'd1) begin
         failures++;
         $display("FAIL arst_pre got led=%b pend=%0d want led=1 pend=1", led, pending);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (led !== 1'b0 || busy !== 1'b0 || pending !== '0) begin
         failures++;
         $display("FAIL arst_immediate got led=%b busy=%b pend=%0d want 0 0 0",
                  led, busy, pending);
      end
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         checks++;
         if (led !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL arst_no_replay cyc=%0d got led=%b busy=%b want 0 0", i, led, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_held();
      test_queue();
      test_last_gap();
      test_saturate();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
